matriz_lane_scroller: RTL and testbench

//  Sequencer for the 8x8 LED matrix lane datapath. It holds four lane column registers
//  (Izq2, Izq1, Der1, Der2) and scrolls them one row toward row 8 on every prescaler period.
//  A single new top-row pattern enters per scroll through a valid/ready handshake.
//  The lane outputs connect directly to the four lane inputs of the matrix row-mapping block
//  (bit0 = Fila1/top, bit DATAWIDTH-1 = Fila8/bottom).

---
 rtl/matriz_lane_scroller.sv | 156 +++++++++++++++
 tb/tb_matriz_lane_scroller.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matriz_lane_scroller.sv
// Four-lane LED column scroller: shifts lanes one row toward Fila8 per prescaler period, one new top row per scroll.
// Latency: accepted pattern enters on the next scroll after the accept clock; Tick/Exit are registered one clock after the scroll.
// Backpressure: PatternReady drops while a pattern is buffered (or outside RUN/PAUSE); Valid without Ready is ignored.
module matriz_lane_scroller #(
  parameter int DATAWIDTH     = 8,
  parameter int PRESC_WIDTH   = 22,
  parameter int SCROLL_PERIOD = 2500000
) (
  input  logic                 MatrizCtrl_CLOCK_50,
  input  logic                 MatrizCtrl_RESET_InLow,
  input  logic                 MatrizCtrl_Start_In,
  input  logic                 MatrizCtrl_Stop_In,
  input  logic                 MatrizCtrl_Pause_In,
  input  logic [3:0]           MatrizCtrl_Pattern_In,
  input  logic                 MatrizCtrl_PatternValid_In,
  output logic                 MatrizCtrl_PatternReady_Out,
  output logic [DATAWIDTH-1:0] MatrizCtrl_Izq2_Out,
  output logic [DATAWIDTH-1:0] MatrizCtrl_Izq1_Out,
  output logic [DATAWIDTH-1:0] MatrizCtrl_Der1_Out,
  output logic [DATAWIDTH-1:0] MatrizCtrl_Der2_Out,
  output logic                 MatrizCtrl_Tick_Out,
  output logic [3:0]           MatrizCtrl_Exit_Out,
  output logic [1:0]           MatrizCtrl_State_Out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_FLUSH = 2'b11
  } state_t;

  localparam logic [PRESC_WIDTH-1:0] PRESC_TERM = PRESC_WIDTH'(SCROLL_PERIOD - 1);
  localparam logic [PRESC_WIDTH-1:0] PRESC_ONE  = PRESC_WIDTH'(1);

  state_t                 state;
  state_t                 state_nxt;
  logic [DATAWIDTH-1:0]   lane_izq2;
  logic [DATAWIDTH-1:0]   lane_izq1;
  logic [DATAWIDTH-1:0]   lane_der1;
  logic [DATAWIDTH-1:0]   lane_der2;
  logic [3:0]             buf_pat;
  logic                   buf_full;
  logic [PRESC_WIDTH-1:0] presc;
  logic [3:0]             exit_bits;
  logic                   tick;

  logic                   counting;
  logic                   scroll;
  logic                   ready;
  logic                   accept;
  logic                   lanes_zero;
  logic                   start_clear;
  logic                   flush_entry;
  logic [3:0]             new_bits;

  // Prescaler only advances in RUN/FLUSH; the scroll fires on its terminal count.
  assign counting    = (state == ST_RUN) || (state == ST_FLUSH);
  assign scroll      = counting && (presc == PRESC_TERM);
  assign ready       = ~buf_full && ((state == ST_RUN) || (state == ST_PAUSE));
  assign accept      = MatrizCtrl_PatternValid_In && ready;
  assign lanes_zero  = ~|{lane_izq2, lane_izq1, lane_der1, lane_der2};
  assign start_clear = (state == ST_IDLE) && MatrizCtrl_Start_In;
  assign flush_entry = (state_nxt == ST_FLUSH) && (state != ST_FLUSH);
  // Only a pattern already buffered before this clock may enter; no accept-to-scroll bypass.
  assign new_bits    = (state == ST_RUN && buf_full) ? buf_pat : 4'b0000;

  // State register.
  always_ff @(posedge MatrizCtrl_CLOCK_50 or negedge MatrizCtrl_RESET_InLow) begin
    if (!MatrizCtrl_RESET_InLow) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode, priority Stop > Pause > Start.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (MatrizCtrl_Start_In) state_nxt = ST_RUN;
      ST_RUN: begin
        if (MatrizCtrl_Stop_In)       state_nxt = ST_FLUSH;
        else if (MatrizCtrl_Pause_In) state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (MatrizCtrl_Stop_In)        state_nxt = ST_FLUSH;
        else if (!MatrizCtrl_Pause_In) state_nxt = ST_RUN;
      end
      ST_FLUSH: if (lanes_zero) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Lane shift, exit capture, prescaler and single-entry pattern buffer.
  always_ff @(posedge MatrizCtrl_CLOCK_50 or negedge MatrizCtrl_RESET_InLow) begin
    if (!MatrizCtrl_RESET_InLow) begin
      lane_izq2 <= '0;
      lane_izq1 <= '0;
      lane_der1 <= '0;
      lane_der2 <= '0;
      buf_pat   <= 4'b0000;
      buf_full  <= 1'b0;
      presc     <= '0;
      exit_bits <= 4'b0000;
      tick      <= 1'b0;
    end else begin
      tick <= scroll;
      if (start_clear) begin
        lane_izq2 <= '0;
        lane_izq1 <= '0;
        lane_der1 <= '0;
        lane_der2 <= '0;
        buf_pat   <= 4'b0000;
        buf_full  <= 1'b0;
        presc     <= '0;
        exit_bits <= 4'b0000;
      end else begin
        if (state == ST_IDLE) begin
          presc <= '0;
        end else if (counting) begin
          presc <= scroll ? '0 : presc + PRESC_ONE;
        end

        if (scroll) begin
          exit_bits <= {lane_der2[DATAWIDTH-1], lane_der1[DATAWIDTH-1],
                        lane_izq1[DATAWIDTH-1], lane_izq2[DATAWIDTH-1]};
          lane_izq2 <= {lane_izq2[DATAWIDTH-2:0], new_bits[0]};
          lane_izq1 <= {lane_izq1[DATAWIDTH-2:0], new_bits[1]};
          lane_der1 <= {lane_der1[DATAWIDTH-2:0], new_bits[2]};
          lane_der2 <= {lane_der2[DATAWIDTH-2:0], new_bits[3]};
        end

        // Entering FLUSH drops any buffered pattern, even one accepted this clock.
        if (flush_entry) begin
          buf_full <= 1'b0;
        end else if (accept) begin
          buf_full <= 1'b1;
          buf_pat  <= MatrizCtrl_Pattern_In;
        end else if (scroll) begin
          buf_full <= 1'b0;
        end
      end
    end
  end

  assign MatrizCtrl_PatternReady_Out = ready;
  assign MatrizCtrl_Izq2_Out         = lane_izq2;
  assign MatrizCtrl_Izq1_Out         = lane_izq1;
  assign MatrizCtrl_Der1_Out         = lane_der1;
  assign MatrizCtrl_Der2_Out         = lane_der2;
  assign MatrizCtrl_Tick_Out         = tick;
  assign MatrizCtrl_Exit_Out         = exit_bits;
  assign MatrizCtrl_State_Out        = state;

endmodule

// File: tb/tb_matriz_lane_scroller.sv
// Bench for matriz_lane_scroller: directed scenarios plus random traffic against a row-arithmetic reference model.
// Latency: model advances on each rising edge; outputs compared on every falling edge.
// Backpressure: bench honours PatternReady when sequencing patterns.
module tb_matriz_lane_scroller;

  localparam int DW   = 8;
  localparam int P    = 4;
  localparam int TOPW = 1 << (DW - 1);
  localparam int MOD  = 1 << DW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic          pause;
  logic [3:0]    pattern;
  logic          valid;
  logic          ready_o;
  logic [DW-1:0] izq2_o;
  logic [DW-1:0] izq1_o;
  logic [DW-1:0] der1_o;
  logic [DW-1:0] der2_o;
  logic          tick_o;
  logic [3:0]    exit_o;
  logic [1:0]    state_o;

  int n_checks = 0;
  int n_fail   = 0;

  matriz_lane_scroller #(.DATAWIDTH(DW), .PRESC_WIDTH(22), .SCROLL_PERIOD(P)) dut (
    .MatrizCtrl_CLOCK_50        (clk),
    .MatrizCtrl_RESET_InLow     (rst_n),
    .MatrizCtrl_Start_In        (start),
    .MatrizCtrl_Stop_In         (stop),
    .MatrizCtrl_Pause_In        (pause),
    .MatrizCtrl_Pattern_In      (pattern),
    .MatrizCtrl_PatternValid_In (valid),
    .MatrizCtrl_PatternReady_Out(ready_o),
    .MatrizCtrl_Izq2_Out        (izq2_o),
    .MatrizCtrl_Izq1_Out        (izq1_o),
    .MatrizCtrl_Der1_Out        (der1_o),
    .MatrizCtrl_Der2_Out        (der2_o),
    .MatrizCtrl_Tick_Out        (tick_o),
    .MatrizCtrl_Exit_Out        (exit_o),
    .MatrizCtrl_State_Out       (state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: lanes as integers (row 1 = weight 1), mode 0 idle 1 run 2 pause 3 flush,
  // phase = clocks elapsed in the current scroll period, pending = patterns waiting to enter.
  int m_mode;
  int m_lane[4];
  int m_exit;
  int m_tick;
  int m_phase;
  int m_pend[$];

  function automatic int m_ready();
    return (m_pend.size() == 0 && (m_mode == 1 || m_mode == 2)) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_exit  = 0;
    m_tick  = 0;
    m_phase = 0;
    m_pend.delete();
    for (int k = 0; k < 4; k++) m_lane[k] = 0;
  endtask

  task automatic model_step();
    int scroll;
    int acc;
    int nxt;
    int b;
    int pat;
    int all_zero;
    scroll   = ((m_mode == 1 || m_mode == 3) && m_phase == P - 1) ? 1 : 0;
    acc      = (valid && m_ready() == 1) ? 1 : 0;
    all_zero = (m_lane[0] + m_lane[1] + m_lane[2] + m_lane[3] == 0) ? 1 : 0;
    nxt      = m_mode;
    case (m_mode)
      0: if (start) nxt = 1;
      1: if (stop) nxt = 3; else if (pause) nxt = 2;
      2: if (stop) nxt = 3; else if (!pause) nxt = 1;
      default: if (all_zero == 1) nxt = 0;
    endcase
    m_tick = scroll;
    if (m_mode == 0) begin
      if (start) begin
        for (int k = 0; k < 4; k++) m_lane[k] = 0;
        m_pend.delete();
        m_exit = 0;
      end
      m_phase = 0;
    end else begin
      if (scroll == 1) begin
        pat = (m_pend.size() > 0) ? m_pend[0] : 0;
        m_exit = 0;
        for (int k = 0; k < 4; k++) begin
          b = (pat >> k) & 1;
          m_exit = m_exit + ((m_lane[k] / TOPW) << k);
          m_lane[k] = (m_lane[k] * 2 + b) % MOD;
        end
        if (m_pend.size() > 0) void'(m_pend.pop_front());
      end
      if (m_mode != 2) m_phase = (m_phase + 1) % P;
      if (acc == 1) m_pend.push_back(int'(pattern));
      if (nxt == 3 && m_mode != 3) m_pend.delete();
    end
    m_mode = nxt;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every falling edge: full output comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("state", int'(state_o), m_mode);
      chk("ready", int'(ready_o), m_ready());
      chk("izq2",  int'(izq2_o),  m_lane[0]);
      chk("izq1",  int'(izq1_o),  m_lane[1]);
      chk("der1",  int'(der1_o),  m_lane[2]);
      chk("der2",  int'(der2_o),  m_lane[3]);
      chk("tick",  int'(tick_o),  m_tick);
      chk("exit",  int'(exit_o),  m_exit);
    end
  end

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_o && n < budget);
    if (!tick_o) chk("tick_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int ticks;
    int idx;
    int acc;
    int guard;
    int cap_izq2;
    int cap_der1;
    logic [3:0] pats [2];
    pats[0] = 4'hF;
    pats[1] = 4'h5;

    rst_n = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; valid = 1'b0; pattern = 4'h0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", int'(state_o), 0);
    chk("rst_ready", int'(ready_o), 0);
    chk("rst_lanes", int'(izq2_o | izq1_o | der1_o | der2_o), 0);
    rst_n = 1'b1;

    // Single pattern walks down Izq2 and falls out through Exit.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; valid = 1'b1; pattern = 4'b0001;
    @(negedge clk); valid = 1'b0;
    wait_tick(16, n);
    chk("s1_latency", n, 3);
    chk("s1_izq2", int'(izq2_o), 8'h01);
    chk("s1_others", int'(izq1_o | der1_o | der2_o), 0);
    for (int i = 0; i < 7; i++) begin
      wait_tick(8, n);
      chk("s1_period", n, P);
    end
    chk("s1_bottom", int'(izq2_o), 8'h80);
    wait_tick(8, n);
    chk("s1_exit", int'(exit_o), 4'b0001);
    chk("s1_empty", int'(izq2_o), 0);

    // Valid held: F then 5, one pattern consumed per scroll.
    valid = 1'b1; pattern = pats[0]; idx = 0; ticks = 0; guard = 0;
    while (ticks < 2 && guard < 40) begin
      acc = (ready_o && valid) ? 1 : 0;
      @(negedge clk);
      guard++;
      if (tick_o) ticks++;
      if (acc == 1) begin
        idx++;
        if (idx < 2) pattern = pats[idx];
        else valid = 1'b0;
      end
    end
    valid = 1'b0;
    chk("s2_ticks", ticks, 2);
    // pattern 5 = {Der2=0,Der1=1,Izq1=0,Izq2=1}
    chk("s2_der2", int'(der2_o), 8'h02);
    chk("s2_izq2", int'(izq2_o), 8'h03);

    // Accept on the scroll clock: that scroll inserts 0, the next one inserts the pattern.
    repeat (3) @(negedge clk);
    valid = 1'b1; pattern = 4'hF;
    @(negedge clk); valid = 1'b0;
    chk("s3_tick", int'(tick_o), 1);
    chk("s3_first", int'(izq2_o & 8'h01), 0);
    wait_tick(8, n);
    chk("s3_second", int'(der2_o & 8'h01), 1);

    // Pause for 10 clocks mid-period.
    @(negedge clk); pause = 1'b1;
    @(negedge clk);
    cap_izq2 = int'(izq2_o);
    cap_der1 = int'(der1_o);
    repeat (9) @(negedge clk);
    chk("s4_state", int'(state_o), 2);
    chk("s4_frozen_izq2", int'(izq2_o), cap_izq2);
    chk("s4_frozen_der1", int'(der1_o), cap_der1);
    pause = 1'b0;
    wait_tick(8, n);
    chk("s4_resume", n, 3);

    // Stop with a buffered pattern; Start during FLUSH is ignored.
    valid = 1'b1; pattern = 4'hA;
    @(negedge clk); valid = 1'b0; stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("s5_flush", int'(state_o), 3);
    chk("s5_ready", int'(ready_o), 0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("s5_start_ignored", int'(state_o), 3);
    n = 0;
    while (state_o != 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("s5_idle", int'(state_o), 0);
    chk("s5_within_8_scrolls", (n <= 8 * P + 2) ? 1 : 0, 1);
    chk("s5_lanes_clear", int'(izq2_o | izq1_o | der1_o | der2_o), 0);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 19) == 0);
      stop    = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      valid   = ($urandom_range(0, 2) != 0);
      pattern = 4'($urandom);
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0; pause = 1'b0; valid = 1'b0;
    n = 0;
    while (state_o != 2'b00 && n < 60) begin
      stop = 1'b1;
      @(negedge clk);
      n++;
    end
    stop = 1'b0;
    chk("rand_back_to_idle", int'(state_o), 0);

    // Async reset mid-FLUSH, then clean restart.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; valid = 1'b1; pattern = 4'hF;
    repeat (20) @(negedge clk);
    valid = 1'b0; stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    @(negedge clk);
    chk("s6_in_flush", int'(state_o), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_state", int'(state_o), 0);
    chk("s6_rst_lanes", int'(izq2_o | izq1_o | der1_o | der2_o), 0);
    chk("s6_rst_tick", int'(tick_o), 0);
    chk("s6_rst_exit", int'(exit_o), 0);
    chk("s6_rst_ready", int'(ready_o), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_tick(12, n);
    // Start edge, then four counting edges up to the scroll.
    chk("s6_first_scroll", n, 4);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
